// File: rtl/fanout_bcast_stage_if.sv
`default_nettype none
// ============================================================================
// fanout_bcast_stage_if : upstream valid/ready bus plus per-sink broadcast bus
// Rev 1.0
// ============================================================================
interface fanout_bcast_stage_if #(
  parameter int WIDTH     = 1,
  parameter int NUM_SINKS = 15
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [NUM_SINKS-1:0] sink_en;
  logic [NUM_SINKS-1:0] out_valid;
  logic [NUM_SINKS-1:0] out_ready;
  logic [WIDTH-1:0]     out_data;

  modport master (
    output in_valid, in_data, sink_en, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, sink_en, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/fanout_bcast_stage.sv
`default_nettype none
// ============================================================================
// fanout_bcast_stage : single-entry launch register broadcast to NUM_SINKS
// consumers, next word accepted once every enabled sink has taken the current.
// Rev 1.0
// ============================================================================
module fanout_bcast_stage #(
  parameter int WIDTH     = 1,
  parameter int NUM_SINKS = 15,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fanout_bcast_stage_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     xfer_count,
  output logic                 timeout_err,
  input  logic                 err_clr
);

  localparam int              WC_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WC_W-1:0] WC_MAX   = WC_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam bit              WDOG_EN  = (TIMEOUT > 0);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [NUM_SINKS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     xfer_count_q, xfer_count_d;
  logic [WC_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 in_ready;
  logic                 accept;
  logic                 wdog_hit;

  always_comb begin
    // Ready as soon as no enabled sink would still be pending after this edge.
    in_ready      = ~|(pending_q & ~bus.out_ready);
    accept        = bus.in_valid & in_ready;

    data_d        = data_q;
    pending_d     = pending_q & ~bus.out_ready;
    xfer_count_d  = xfer_count_q;
    if (accept) begin
      data_d    = bus.in_data;
      pending_d = bus.sink_en;
      if (xfer_count_q != CNT_MAX) begin
        xfer_count_d = xfer_count_q + CNT_W'(1);
      end
    end
    state_d = (pending_d != '0) ? BCAST : IDLE;

    // Counter saturates at TIMEOUT so the flag keeps re-arming while stalled.
    wait_cnt_d = wait_cnt_q;
    if (accept || (state_q == IDLE)) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WC_MAX) begin
      wait_cnt_d = wait_cnt_q + WC_W'(1);
    end

    wdog_hit      = WDOG_EN && (state_q == BCAST) && (wait_cnt_q == WC_MAX);
    timeout_err_d = timeout_err_q;
    if (wdog_hit) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_q        <= '0;
      pending_q     <= '0;
      xfer_count_q  <= '0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      pending_q     <= pending_d;
      xfer_count_q  <= xfer_count_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = pending_q;
  assign bus.out_data  = data_q;
  assign busy          = |pending_q;
  assign xfer_count    = xfer_count_q;
  assign timeout_err   = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fanout_bcast_stage.sv
`default_nettype none
// ============================================================================
// tb_fanout_bcast_stage : directed checks of the broadcast stage
// Rev 1.0
// ============================================================================
module tb_fanout_bcast_stage;

  logic        clk;
  logic        rst_n;
  logic        err_clr;
  logic        busy;
  logic [15:0] xfer_count;
  logic        timeout_err;
  logic        busy2;
  logic [2:0]  cnt2;
  logic        terr2;

  int checks = 0;
  int passed = 0;

  fanout_bcast_stage_if #(.WIDTH(8), .NUM_SINKS(4)) bif ();
  fanout_bcast_stage_if #(.WIDTH(8), .NUM_SINKS(4)) sif ();

  fanout_bcast_stage #(.WIDTH(8), .NUM_SINKS(4), .CNT_W(16), .TIMEOUT(5)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif.slave), .busy(busy),
    .xfer_count(xfer_count), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  fanout_bcast_stage #(.WIDTH(8), .NUM_SINKS(4), .CNT_W(3), .TIMEOUT(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sif.slave), .busy(busy2),
    .xfer_count(cnt2), .timeout_err(terr2), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got time limit expected finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0; err_clr = 1'b0;
    bif.in_valid = 0; bif.in_data = 0; bif.sink_en = 0; bif.out_ready = 0;
    sif.in_valid = 0; sif.in_data = 0; sif.sink_en = 0; sif.out_ready = 0;
    #2;
    checks++; if (bif.in_ready !== 1'b1) $display("FAIL in_rst_in_ready: got %b exp 1", bif.in_ready); else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bif.in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b exp 1", bif.in_ready); else passed++;
    checks++; if (bif.out_valid !== 4'b0000) $display("FAIL rst_out_valid: got %b exp 0000", bif.out_valid); else passed++;
    checks++; if (bif.out_data !== 8'h00) $display("FAIL rst_out_data: got %h exp 00", bif.out_data); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else passed++;
    checks++; if (xfer_count !== 16'd0) $display("FAIL rst_xfer_count: got %0d exp 0", xfer_count); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b exp 0", timeout_err); else passed++;
    checks++; if (cnt2 !== 3'd0) $display("FAIL rst_cnt2: got %0d exp 0", cnt2); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bif.in_valid = 1'b1; bif.in_data = 8'(8'h10 + i);
      bif.sink_en = 4'b1111; bif.out_ready = 4'b1111;
      @(negedge clk);
      checks++; if (bif.in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b exp 1", i, bif.in_ready); else passed++;
      if (i > 0) begin
        checks++; if (bif.out_valid !== 4'b1111) $display("FAIL b2b_out_valid[%0d]: got %b exp 1111", i, bif.out_valid); else passed++;
        checks++; if (bif.out_data !== 8'(8'h10 + i - 1)) $display("FAIL b2b_out_data[%0d]: got %h exp %h", i, bif.out_data, 8'(8'h10 + i - 1)); else passed++;
      end
    end
    @(posedge clk); #1 bif.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bif.out_data !== 8'h17) $display("FAIL b2b_last_data: got %h exp 17", bif.out_data); else passed++;
    checks++; if (xfer_count !== 16'd8) $display("FAIL b2b_xfer_count: got %0d exp 8", xfer_count); else passed++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bif.out_valid !== 4'b0000) $display("FAIL b2b_drain_valid: got %b exp 0000", bif.out_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL b2b_drain_busy: got %b exp 0", busy); else passed++;
  endtask

  task automatic test_staircase();
    logic [3:0] rdy   [5] = '{4'b0000, 4'b0001, 4'b0101, 4'b0111, 4'b1111};
    logic [3:0] exp_v [5] = '{4'b1111, 4'b1111, 4'b1110, 4'b1010, 4'b1000};
    logic       exp_r [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    bif.in_valid = 1'b1; bif.in_data = 8'h01; bif.sink_en = 4'b1111; bif.out_ready = 4'b0000;
    @(posedge clk); #1;
    bif.in_data = 8'h02;
    for (int k = 0; k < 5; k++) begin
      bif.out_ready = rdy[k];
      if (k == 4) bif.in_valid = 1'b0;
      @(negedge clk);
      checks++; if (bif.out_valid !== exp_v[k]) $display("FAIL stair_out_valid[%0d]: got %b exp %b", k, bif.out_valid, exp_v[k]); else passed++;
      checks++; if (bif.in_ready !== exp_r[k]) $display("FAIL stair_in_ready[%0d]: got %b exp %b", k, bif.in_ready, exp_r[k]); else passed++;
      checks++; if (bif.out_data !== 8'h01) $display("FAIL stair_out_data[%0d]: got %h exp 01", k, bif.out_data); else passed++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (bif.out_valid !== 4'b0000) $display("FAIL stair_done_valid: got %b exp 0000", bif.out_valid); else passed++;
    checks++; if (bif.out_data !== 8'h01) $display("FAIL stair_blocked_data: got %h exp 01", bif.out_data); else passed++;
    checks++; if (xfer_count !== 16'd9) $display("FAIL stair_xfer_count: got %0d exp 9", xfer_count); else passed++;
    checks++; if (timeout_err !== 1'b0) $display("FAIL stair_timeout_err: got %b exp 0", timeout_err); else passed++;
  endtask

  task automatic test_sink_enable();
    @(posedge clk); #1;
    bif.in_valid = 1'b1; bif.in_data = 8'h5A; bif.sink_en = 4'b0101; bif.out_ready = 4'b0000;
    @(posedge clk); #1;
    bif.in_valid = 1'b0; bif.sink_en = 4'b1111;
    @(negedge clk);
    checks++; if (bif.out_valid !== 4'b0101) $display("FAIL en_out_valid: got %b exp 0101", bif.out_valid); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL en_busy: got %b exp 1", busy); else passed++;
    @(posedge clk); #1 bif.out_ready = 4'b0001;
    @(posedge clk); #1 bif.out_ready = 4'b0100;
    @(negedge clk);
    checks++; if (bif.out_valid !== 4'b0100) $display("FAIL en_partial_valid: got %b exp 0100", bif.out_valid); else passed++;
    checks++; if (bif.in_ready !== 1'b1) $display("FAIL en_in_ready: got %b exp 1", bif.in_ready); else passed++;
    @(posedge clk); #1 bif.out_ready = 4'b0000;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL en_done_busy: got %b exp 0", busy); else passed++;
    checks++; if (bif.out_data !== 8'h5A) $display("FAIL en_out_data: got %h exp 5a", bif.out_data); else passed++;
    // sink_en of zero: the word is counted and latched but never broadcast
    @(posedge clk); #1;
    bif.in_valid = 1'b1; bif.in_data = 8'hC3; bif.sink_en = 4'b0000;
    @(posedge clk); #1 bif.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bif.out_valid !== 4'b0000) $display("FAIL drop_out_valid: got %b exp 0000", bif.out_valid); else passed++;
    checks++; if (bif.out_data !== 8'hC3) $display("FAIL drop_out_data: got %h exp c3", bif.out_data); else passed++;
    checks++; if (xfer_count !== 16'd11) $display("FAIL drop_xfer_count: got %0d exp 11", xfer_count); else passed++;
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    bif.in_valid = 1'b1; bif.in_data = 8'h77; bif.sink_en = 4'b1111; bif.out_ready = 4'b0000;
    @(posedge clk); #1 bif.in_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (timeout_err !== 1'b0) $display("FAIL to_early[%0d]: got %b exp 0", k, timeout_err); else passed++;
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) $display("FAIL to_set: got %b exp 1", timeout_err); else passed++;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    bif.out_ready = 4'b1111;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) $display("FAIL to_set_wins: got %b exp 1", timeout_err); else passed++;
    checks++; if (bif.in_ready !== 1'b1) $display("FAIL to_release_ready: got %b exp 1", bif.in_ready); else passed++;
    @(posedge clk); #1;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    checks++; if (timeout_err !== 1'b0) $display("FAIL to_cleared: got %b exp 0", timeout_err); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL to_busy: got %b exp 0", busy); else passed++;
    checks++; if (xfer_count !== 16'd12) $display("FAIL to_xfer_count: got %0d exp 12", xfer_count); else passed++;
  endtask

  task automatic test_saturation_and_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      sif.in_valid = 1'b1; sif.in_data = 8'(8'h30 + i);
      sif.sink_en = 4'b1111; sif.out_ready = 4'b1111;
      @(negedge clk);
      checks++; if (cnt2 !== 3'((i < 7) ? i : 7)) $display("FAIL sat_count[%0d]: got %0d exp %0d", i, cnt2, (i < 7) ? i : 7); else passed++;
    end
    @(posedge clk); #1 sif.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (cnt2 !== 3'd7) $display("FAIL sat_final: got %0d exp 7", cnt2); else passed++;
    @(posedge clk); #1;
    sif.in_valid = 1'b1; sif.in_data = 8'hEE; sif.out_ready = 4'b0000;
    @(posedge clk); #1 sif.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (sif.out_valid !== 4'b1111) $display("FAIL sat_bcast_valid: got %b exp 1111", sif.out_valid); else passed++;
    checks++; if (sif.out_data !== 8'hEE) $display("FAIL sat_bcast_data: got %h exp ee", sif.out_data); else passed++;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (terr2 !== 1'b0) $display("FAIL wdog_disabled: got %b exp 0", terr2); else passed++;
    // Asynchronous reset away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sif.out_valid !== 4'b0000) $display("FAIL arst_out_valid: got %b exp 0000", sif.out_valid); else passed++;
    checks++; if (busy2 !== 1'b0) $display("FAIL arst_busy: got %b exp 0", busy2); else passed++;
    checks++; if (cnt2 !== 3'd0) $display("FAIL arst_cnt2: got %0d exp 0", cnt2); else passed++;
    checks++; if (sif.out_data !== 8'h00) $display("FAIL arst_out_data: got %h exp 00", sif.out_data); else passed++;
    checks++; if (sif.in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b exp 1", sif.in_ready); else passed++;
    checks++; if (xfer_count !== 16'd0) $display("FAIL arst_xfer_count: got %0d exp 0", xfer_count); else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_staircase();
    test_sink_enable();
    test_timeout();
    test_saturation_and_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
